// File: rtl/alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter : two-port valid/ready arbiter sharing one 32-bit ALU, with a
//               registered, tagged response channel. Optional perf counters
//               are built when ALU_ARB_PERF_EN is defined.
// Revision    : 1.0
// ---------------------------------------------------------------------------

module alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  aluc_i,
  output logic [31:0] r_o,
  output logic        z_o
);
  always_comb begin
    casez (aluc_i)
      4'b?000: r_o = a_i + b_i;
      4'b?100: r_o = a_i - b_i;
      4'b?001: r_o = a_i & b_i;
      4'b?101: r_o = a_i | b_i;
      4'b?010: r_o = a_i ^ b_i;
      4'b?110: r_o = {b_i[15:0], 16'h0000};
      4'b?011: r_o = b_i << a_i[4:0];
      4'b0111: r_o = b_i >> a_i[4:0];
      4'b1111: r_o = $signed(b_i) >>> a_i[4:0];
      default: r_o = '0;
    endcase
    z_o = (r_o == 32'd0);
  end
endmodule

module alu_arbiter #(
  parameter int DATA_W        = 32,
  parameter int PRIORITY_MODE = 0
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_aluc,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_aluc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_z
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       cnt_grant0,
  output logic [15:0]       cnt_grant1,
  output logic [15:0]       cnt_conflict
`endif
);

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_r_q, rsp_r_d;
  logic              rsp_z_q, rsp_z_d;
  logic              lp_q, lp_d;

  logic              slot_free;
  logic              grant;
  logic              handshake;
  logic [DATA_W-1:0] alu_a, alu_b, alu_r;
  logic [3:0]        alu_c;
  logic              alu_z;

  // Grant is purely combinational; nothing is held between cycles except lp.
  always_comb begin
    slot_free = ~rsp_valid_q | rsp_ready;
    case ({req1_valid, req0_valid})
      2'b10:   grant = 1'b1;
      2'b11:   grant = (PRIORITY_MODE == 0) ? ~lp_q : 1'b0;
      default: grant = 1'b0;
    endcase
    req0_ready = slot_free & req0_valid & ~grant;
    req1_ready = slot_free & req1_valid & grant;
    handshake  = req0_ready | req1_ready;
    alu_a      = grant ? req1_a    : req0_a;
    alu_b      = grant ? req1_b    : req0_b;
    alu_c      = grant ? req1_aluc : req0_aluc;
  end

  alu u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .aluc_i (alu_c),
    .r_o    (alu_r),
    .z_o    (alu_z)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    rsp_z_d     = rsp_z_q;
    lp_d        = lp_q;
    if (handshake) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant;
      rsp_r_d     = alu_r;
      rsp_z_d     = alu_z;
      lp_d        = grant;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // lp resets to 1 so that port 0 wins the first conflict.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= '0;
      rsp_z_q     <= 1'b0;
      lp_q        <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_z_q     <= rsp_z_d;
      lp_q        <= lp_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_z     = rsp_z_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] cnt_grant0_q, cnt_grant1_q, cnt_conflict_q;
  logic        conflict;

  assign conflict = req0_valid & req1_valid & handshake;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_grant0_q   <= 16'h0000;
      cnt_grant1_q   <= 16'h0000;
      cnt_conflict_q <= 16'h0000;
    end else begin
      if (req0_ready && cnt_grant0_q != 16'hFFFF)
        cnt_grant0_q <= cnt_grant0_q + 16'd1;
      if (req1_ready && cnt_grant1_q != 16'hFFFF)
        cnt_grant1_q <= cnt_grant1_q + 16'd1;
      if (conflict && cnt_conflict_q != 16'hFFFF)
        cnt_conflict_q <= cnt_conflict_q + 16'd1;
    end
  end

  assign cnt_grant0   = cnt_grant0_q;
  assign cnt_grant1   = cnt_grant1_q;
  assign cnt_conflict = cnt_conflict_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_arbiter : scoreboard bench; one round-robin and one fixed-priority
//                  instance, directed scenarios followed by random traffic.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] r;
    logic        z;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done0  = 1'b0;
  bit done1  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: returns {zero, result}
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [31:0] r;
    int unsigned sh;
    sh = a % 32;
    case (c[2:0])
      3'd0: r = a + b;
      3'd4: r = a - b;
      3'd1: r = a & b;
      3'd5: r = a | b;
      3'd2: r = a ^ b;
      3'd6: r = b * 32'd65536;
      3'd3: r = b << sh;
      default: r = (c[3] && b[31]) ? ~((~b) >> sh) : (b >> sh);
    endcase
    return {r == 32'd0, r};
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int MODE = g;

      logic        clrn;
      logic        v0, v1, rdy0, rdy1, rspv, rr, id, z;
      logic [31:0] a0, b0, a1, b1, r;
      logic [3:0]  c0, c1;
`ifdef ALU_ARB_PERF_EN
      logic [15:0] cg0, cg1, ccf;
      int          mg0, mg1, mcf;
`endif

      rsp_t q[$];
      bit   mv, lastp, have_last;
      rsp_t last;

      alu_arbiter #(.DATA_W(32), .PRIORITY_MODE(MODE)) u_dut (
        .clk        (clk),
        .clrn       (clrn),
        .req0_valid (v0),
        .req0_ready (rdy0),
        .req0_a     (a0),
        .req0_b     (b0),
        .req0_aluc  (c0),
        .req1_valid (v1),
        .req1_ready (rdy1),
        .req1_a     (a1),
        .req1_b     (b1),
        .req1_aluc  (c1),
        .rsp_valid  (rspv),
        .rsp_ready  (rr),
        .rsp_id     (id),
        .rsp_r      (r),
        .rsp_z      (z)
`ifdef ALU_ARB_PERF_EN
        ,
        .cnt_grant0   (cg0),
        .cnt_grant1   (cg1),
        .cnt_conflict (ccf)
`endif
      );

      function automatic string nm(input string s);
        return $sformatf("mode%0d %s", MODE, s);
      endfunction

      // One cycle of stimulus: drive, predict readys, enqueue the expected response.
      task automatic step(input bit iv0, input logic [31:0] ia0, input logic [31:0] ib0,
                          input logic [3:0] ic0, input bit iv1, input logic [31:0] ia1,
                          input logic [31:0] ib1, input logic [3:0] ic1, input bit irr,
                          output bit h0, output bit h1);
        bit slot, w;
        logic [32:0] res;
        @(negedge clk);
        v0 = iv0; a0 = ia0; b0 = ib0; c0 = ic0;
        v1 = iv1; a1 = ia1; b1 = ib1; c1 = ic1;
        rr = irr;
        #1;
`ifdef ALU_ARB_PERF_EN
        check(nm("cnt_grant0"), 64'(cg0), 64'(mg0));
        check(nm("cnt_grant1"), 64'(cg1), 64'(mg1));
        check(nm("cnt_conflict"), 64'(ccf), 64'(mcf));
`endif
        slot = !mv || irr;
        if (iv0 && iv1) w = (MODE == 1) ? 1'b0 : !lastp;
        else            w = iv1;
        h0 = slot && iv0 && !w;
        h1 = slot && iv1 && w;
        check(nm("req0_ready"), 64'(rdy0), 64'(h0));
        check(nm("req1_ready"), 64'(rdy1), 64'(h1));
        if (h0 || h1) begin
          res = w ? alu_ref(ia1, ib1, ic1) : alu_ref(ia0, ib0, ic0);
          q.push_back('{id: w, r: res[31:0], z: res[32]});
          lastp = w;
          mv    = 1'b1;
`ifdef ALU_ARB_PERF_EN
          if (h0 && mg0 < 65535) mg0++;
          if (h1 && mg1 < 65535) mg1++;
          if (iv0 && iv1 && mcf < 65535) mcf++;
`endif
        end else if (irr) begin
          mv = 1'b0;
        end
      endtask

      // Monitor: compares whatever the DUT hands over against the queue head.
      always @(negedge clk) begin
        rsp_t cur, exp;
        #2;
        if (clrn === 1'b1) begin
          if (rspv) begin
            cur = '{id: id, r: r, z: z};
            if (have_last) check(nm("rsp held"), 64'(cur), 64'(last));
            if (rr) begin
              if (q.size() == 0) begin
                check(nm("rsp unexpected"), 64'(cur), 64'h0);
                check(nm("rsp queue"), 64'(q.size()), 64'd1);
              end else begin
                exp = q.pop_front();
                check(nm("rsp {id,r,z}"), 64'(cur), 64'(exp));
              end
              have_last = 1'b0;
            end else begin
              last      = cur;
              have_last = 1'b1;
            end
          end else begin
            have_last = 1'b0;
          end
        end
      end

      initial begin
        bit          d0, d1;
        bit          pv[2];
        bit          acc[2];
        logic [31:0] pa[2], pb[2];
        logic [3:0]  pc[2];

        clrn = 1'b0; rr = 1'b0;
        v0 = 1'b0; a0 = '0; b0 = '0; c0 = '0;
        v1 = 1'b0; a1 = '0; b1 = '0; c1 = '0;
        mv = 1'b0; lastp = 1'b1; have_last = 1'b0;
`ifdef ALU_ARB_PERF_EN
        mg0 = 0; mg1 = 0; mcf = 0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check(nm("reset rsp_valid"), 64'(rspv), 64'd0);
        check(nm("reset {id,r,z}"), 64'({id, r, z}), 64'd0);
        @(negedge clk);
        clrn = 1'b1;

        // Single-port add, then zero flag from a subtract on port 1
        step(1, 32'd5, 32'd3, 4'b0000, 0, 32'd0, 32'd0, 4'b0000, 1, d0, d1);
        step(0, 32'd0, 32'd0, 4'b0000, 1, 32'd7, 32'd7, 4'b0100, 1, d0, d1);
        // Both ports valid with a free slot: alternation or port-0 priority
        repeat (4) step(1, 32'd20, 32'd6, 4'b0100, 1, 32'hF0, 32'h0F, 4'b0101, 1, d0, d1);
        // Backpressure: one accept, three stalled cycles, then drain+accept
        step(1, 32'd1, 32'd2, 4'b0000, 1, 32'd4, 32'h80000000, 4'b1111, 1, d0, d1);
        repeat (3) step(1, 32'd1, 32'd2, 4'b0000, 1, 32'd4, 32'h80000000, 4'b1111, 0, d0, d1);
        step(1, 32'd1, 32'd2, 4'b0000, 1, 32'd4, 32'h80000000, 4'b1111, 1, d0, d1);
        // Port 0 drops: port 1 now accepted in either mode
        step(0, 32'd0, 32'd0, 4'b0000, 1, 32'd4, 32'h80000000, 4'b1111, 1, d0, d1);

        pv[0] = 0; pv[1] = 0; acc[0] = 0; acc[1] = 0;
        for (int n = 0; n < 300; n++) begin
          for (int p = 0; p < 2; p++) begin
            if (pv[p] && !acc[p]) begin
              if ($urandom_range(0, 3) == 0) pv[p] = 1'b0;
            end else begin
              pv[p] = ($urandom_range(0, 2) != 0);
              pa[p] = $urandom;
              pb[p] = ($urandom_range(0, 5) == 0) ? pa[p] : $urandom;
              pc[p] = 4'($urandom_range(0, 15));
            end
          end
          step(pv[0], pa[0], pb[0], pc[0], pv[1], pa[1], pb[1], pc[1],
               ($urandom_range(0, 3) != 0), acc[0], acc[1]);
        end

        // Reset with a response pending
        step(0, 32'd0, 32'd0, 4'b0000, 0, 32'd0, 32'd0, 4'b0000, 1, d0, d1);
        step(0, 32'd0, 32'd0, 4'b0000, 0, 32'd0, 32'd0, 4'b0000, 1, d0, d1);
        step(1, 32'd9, 32'd9, 4'b0100, 0, 32'd0, 32'd0, 4'b0000, 0, d0, d1);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
        #1;
        check(nm("pre-reset rsp_valid"), 64'(rspv), 64'd1);
        #2;
        clrn = 1'b0;
        #1;
        check(nm("async reset rsp_valid"), 64'(rspv), 64'd0);
        check(nm("async reset {id,r,z}"), 64'({id, r, z}), 64'd0);
        q.delete();
        mv = 1'b0; lastp = 1'b1; have_last = 1'b0;
`ifdef ALU_ARB_PERF_EN
        mg0 = 0; mg1 = 0; mcf = 0;
`endif
        @(negedge clk);
        clrn = 1'b1;
        step(1, 32'd3, 32'd3, 4'b0010, 1, 32'd1, 32'd1, 4'b0000, 1, d0, d1);
        check(nm("first grant after reset"), 64'({d1, d0}), 64'b01);
        step(0, 32'd0, 32'd0, 4'b0000, 1, 32'd1, 32'd1, 4'b0000, 1, d0, d1);
        repeat (3) step(0, 32'd0, 32'd0, 4'b0000, 0, 32'd0, 32'd0, 4'b0000, 1, d0, d1);
        @(negedge clk);
        #3;
        check(nm("drained"), 64'(q.size()), 64'd0);
        if (MODE == 0) done0 = 1'b1;
        else           done1 = 1'b1;
      end
    end
  endgenerate

  initial begin
    for (int i = 0; i < 20000; i++) begin
      if (done0 && done1) break;
      @(negedge clk);
    end
    if (!(done0 && done1)) begin
      errors++;
      checks++;
      $display("FAIL timeout: done=%b%b expected 11", done1, done0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
